// File: rtl/sigmoid_alu_multiplier.sv
// rtl/sigmoid_alu_multiplier.sv - signed-by-unsigned 4x4 shift-and-add multiplier with registered copy
module sigmoid_alu_multiplier (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] signval,
    input  logic [3:0] unsignval,
    input  logic       in_valid,
    output logic [7:0] out,
    output logic [7:0] out_q,
    output logic       out_valid
);

    logic [7:0] sext;
    logic [7:0] pp;
    logic [7:0] acc;
    logic [7:0] sum;
    logic       carry;
    logic [7:0] out_q_d;
    logic       out_valid_d;

    // Each partial product is folded into the running sum by an 8-bit
    // full-adder ripple chain; carry past bit 7 is dropped since the
    // sign-extended operands already make the 8-bit result exact.
    always_comb begin
        sext  = {{4{signval[3]}}, signval};
        acc   = 8'h00;
        sum   = 8'h00;
        pp    = 8'h00;
        carry = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pp    = unsignval[k] ? (sext << k) : 8'h00;
            carry = 1'b0;
            for (int b = 0; b < 8; b++) begin
                sum[b] = acc[b] ^ pp[b] ^ carry;
                carry  = (acc[b] & pp[b]) | (acc[b] & carry) | (pp[b] & carry);
            end
            acc = sum;
        end
    end

    assign out = acc;

    always_comb begin
        out_q_d     = out_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            out_q_d     = out;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            out_q     <= out_q_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_sigmoid_alu_multiplier.sv
// tb/tb_sigmoid_alu_multiplier.sv - directed and sweep checks for sigmoid_alu_multiplier
`timescale 1ns/100ps
module tb_sigmoid_alu_multiplier;

    logic       clk;
    logic       rst;
    logic [3:0] signval;
    logic [3:0] unsignval;
    logic       in_valid;
    logic [7:0] out;
    logic [7:0] out_q;
    logic       out_valid;

    int n_checks;
    int n_pass;

    sigmoid_alu_multiplier dut (
        .clk       (clk),
        .rst       (rst),
        .signval   (signval),
        .unsignval (unsignval),
        .in_valid  (in_valid),
        .out       (out),
        .out_q     (out_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic comb_case(input string tag, input logic [3:0] s, input logic [3:0] u,
                             input logic [7:0] exp);
        signval   = s;
        unsignval = u;
        #4.9;
        check(tag, out, exp);
        #0.1;
    endtask

    initial begin
        int prod;
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        signval   = 4'h0;
        unsignval = 4'h0;

        // Reset held for two cycles
        @(posedge clk); @(posedge clk); #1;
        check("rst_out_q", out_q, 8'h00);
        check("rst_out_valid", {7'b0, out_valid}, 8'h00);

        // Accept (-3, 5)
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b1; signval = 4'hD; unsignval = 4'h5;
        @(posedge clk); #1;
        check("reg_out_q", out_q, 8'hF1);
        check("reg_out_valid", {7'b0, out_valid}, 8'h01);

        // in_valid low: pulse ends, value holds
        @(negedge clk);
        in_valid = 1'b0; signval = 4'h2; unsignval = 4'h3;
        @(posedge clk); #1;
        check("hold_out_q", out_q, 8'hF1);
        check("hold_out_valid", {7'b0, out_valid}, 8'h00);
        check("hold_out_comb", out, 8'h06);

        // Reset beats in_valid in the same cycle
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; signval = 4'h7; unsignval = 4'hF;
        @(posedge clk); #1;
        check("prio_out_q", out_q, 8'h00);
        check("prio_out_valid", {7'b0, out_valid}, 8'h00);
        check("prio_out_comb", out, 8'h69);

        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;

        // Directed corner vectors
        comb_case("zero_s",   4'h0, 4'hF, 8'h00);
        comb_case("zero_u_m8", 4'h8, 4'h0, 8'h00);
        comb_case("zero_u_m1", 4'hF, 4'h0, 8'h00);
        comb_case("m8x1",     4'h8, 4'h1, 8'hF8);
        comb_case("m8x8",     4'h8, 4'h8, 8'hC0);
        comb_case("p7x8",     4'h7, 4'h8, 8'h38);
        comb_case("m8x15",    4'h8, 4'hF, 8'h88);
        comb_case("p7x15",    4'h7, 4'hF, 8'h69);
        comb_case("m1x1",     4'hF, 4'h1, 8'hFF);

        // Exhaustive sweep
        for (int i = -8; i < 8; i++) begin
            for (int j = 0; j < 16; j++) begin
                prod = i * j;
                comb_case($sformatf("sweep_%0d_%0d", i, j), i[3:0], j[3:0], prod[7:0]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sigmoid_alu_multiplier.md
# sigmoid_alu_multiplier

Signed-by-unsigned 4x4 multiplier used inside the sigmoid ALU of the digit-recognizer datapath. It multiplies a 4-bit two's-complement operand by a 4-bit unsigned operand and produces an exact 8-bit two's-complement product. The combinational product is the primary output. A registered copy with a valid flag is provided for pipelined consumers. The block sits between the sigmoid coefficient lookup (the signed operand) and the ALU accumulator.

## Interface
Parameters: none; all widths are fixed.

Ports:
- clk  input  1  system clock; the only clock; rising-edge.
- rst  input  1  synchronous, active-high reset; affects registered outputs only.
- signval  input  4  multiplicand, two's complement, range -8..7.
- unsignval  input  4  multiplier, unsigned, range 0..15.
- in_valid  input  1  qualifies signval/unsignval for the registered path.
- out  output  8  combinational product signval*unsignval, two's complement.
- out_q  output  8  registered product; reset value 8'h00.
- out_valid  output  1  registered in_valid; reset value 0.

## Operation
- out = sext(signval) * zext(unsignval), computed exactly with no saturation or rounding.
- The full result range is -120 (-8*15) to 105 (7*15). It always fits in 8-bit signed, so overflow cannot occur.
- Structure: a shift-and-add array; the `*` operator is not used.
  - Partial product k (k = 0..3) = (unsignval[k] ? sext8(signval) : 0) << k.
  - The four partial products are summed with 8-bit ripple-carry adders built from full-adder cells.
  - Carry-out beyond bit 7 is discarded; sign correctness comes from the 8-bit sign extension.
- Any operand equal to 0 gives out = 0. This includes signval = 0 with any unsignval, and unsignval = 0 with signval = -8.
- out depends only on signval and unsignval. It is independent of clk, rst and in_valid.
- Registered path, evaluated on each rising clk:
  - If rst: out_q <= 0 and out_valid <= 0.
  - Else if in_valid: out_q <= out and out_valid <= 1.
  - Else: out_q holds its value and out_valid <= 0.
- rst has priority over in_valid when both are high in the same cycle.

## Timing
- out is purely combinational. It must settle within 4.9 ns of an input change; that window is the check point of the 5 ns verification step.
- Registered path latency is 1 cycle: inputs present at edge N appear on out_q/out_valid after edge N.
- out_valid is a single-cycle pulse per accepted input. There is no backpressure.
- Reset is synchronous. Asserting rst mid-stream clears out_q/out_valid at the next edge, and any operand presented in that cycle is dropped. out keeps tracking the inputs during reset.
- There are no multicycle paths and no internal state other than out_q/out_valid.

## Test plan
- Exhaustive sweep: signval -8..7 crossed with unsignval 0..15, 256 cases, inputs held 5 ns each -> $signed(out) == i*j in every case. For example, -8*15 -> 8'h88 (-120), 7*15 -> 8'h69 (105), -1*1 -> 8'hFF.
- Zero handling: (0, 15) -> 0; (-8, 0) -> 0; (-1, 0) -> 0.
- Sign boundary: (-8, 1) -> 8'hF8; (-8, 8) -> 8'hC0 (-64); (7, 8) -> 8'h38 (56).
- Registered path: hold rst=1 for 2 cycles -> out_q=0 and out_valid=0. Then apply in_valid=1 with (-3, 5) -> after one edge out_q=8'hF1 (-15) and out_valid=1. Drop in_valid -> out_valid=0 and out_q holds 8'hF1.
- Reset priority: rst=1 and in_valid=1 with (7, 15) in the same cycle -> out_q=0 and out_valid=0 after the edge, while out=8'h69 combinationally.
